// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and data access: data has priority,
// a starvation guard forces a fetch grant, and at most one transaction is outstanding.
module mem_port_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 24,
  parameter int STARVE_MAX = 3
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_if_req,
  input  logic [ADDR_W-1:0] iw_if_addr,
  output logic              ow_if_ack,
  output logic [DATA_W-1:0] ow_if_rdata,
  output logic              ow_if_stall,
  input  logic              iw_da_req,
  input  logic              iw_da_we,
  input  logic [ADDR_W-1:0] iw_da_addr,
  input  logic [DATA_W-1:0] iw_da_wdata,
  output logic              ow_da_ack,
  output logic [DATA_W-1:0] ow_da_rdata,
  output logic              ow_da_stall,
  output logic              ow_mem_req,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  input  logic              iw_mem_rvalid,
  input  logic [DATA_W-1:0] iw_mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_DA = 2'd1,
    BUSY_IF = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_ack_q, if_ack_d;
  logic                da_ack_q, da_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   da_rdata_q, da_rdata_d;

  logic if_elig, da_elig, starve_hit, grant_da, grant_if;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ack_d     = 1'b0;
    da_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    da_rdata_d   = da_rdata_q;
    grant_da     = 1'b0;
    grant_if     = 1'b0;

    // A requester is never re-granted in the cycle its ack is showing.
    if_elig    = iw_if_req & ~if_ack_q;
    da_elig    = iw_da_req & ~da_ack_q;
    starve_hit = (starve_cnt_q == CNT_W'(STARVE_MAX));

    case (state_q)
      IDLE: begin
        if (da_elig && !(if_elig && starve_hit)) grant_da = 1'b1;
        else if (if_elig)                        grant_if = 1'b1;
      end
      BUSY_DA: begin
        if (iw_mem_rvalid) begin
          state_d  = IDLE;
          da_ack_d = 1'b1;
          if (!mem_we_q) da_rdata_d = iw_mem_rdata;
        end
      end
      BUSY_IF: begin
        if (iw_mem_rvalid) begin
          state_d    = IDLE;
          if_ack_d   = 1'b1;
          if_rdata_d = iw_mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_da) begin
      state_d     = BUSY_DA;
      mem_req_d   = 1'b1;
      mem_we_d    = iw_da_we;
      mem_addr_d  = iw_da_addr;
      mem_wdata_d = iw_da_wdata;
    end else if (grant_if) begin
      state_d     = BUSY_IF;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = iw_if_addr;
      mem_wdata_d = '0;
    end

    if (!iw_if_req || grant_if)      starve_cnt_d = '0;
    else if (grant_da && !starve_hit) starve_cnt_d = starve_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      da_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      da_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      da_ack_q     <= da_ack_d;
      if_rdata_q   <= if_rdata_d;
      da_rdata_q   <= da_rdata_d;
    end
  end

  assign ow_mem_req   = mem_req_q;
  assign ow_mem_we    = mem_we_q;
  assign ow_mem_addr  = mem_addr_q;
  assign ow_mem_wdata = mem_wdata_q;
  assign ow_if_ack    = if_ack_q;
  assign ow_if_rdata  = if_rdata_q;
  assign ow_da_ack    = da_ack_q;
  assign ow_da_rdata  = da_rdata_q;
  // Stalls are held low during reset so every output reads 0 while iw_rst is high.
  assign ow_if_stall  = iw_if_req & ~if_ack_q & ~iw_rst;
  assign ow_da_stall  = iw_da_req & ~da_ack_q & ~iw_rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: randomized requesters and memory, transaction-level
// reference model feeding expectation queues, monitor comparing on every DUT strobe.
module tb_mem_port_arbiter;
  localparam int AW = 24;
  localparam int DW = 24;
  localparam int SM = 3;

  logic          iw_clk, iw_rst;
  logic          iw_if_req;
  logic [AW-1:0] iw_if_addr;
  logic          ow_if_ack;
  logic [DW-1:0] ow_if_rdata;
  logic          ow_if_stall;
  logic          iw_da_req, iw_da_we;
  logic [AW-1:0] iw_da_addr;
  logic [DW-1:0] iw_da_wdata;
  logic          ow_da_ack;
  logic [DW-1:0] ow_da_rdata;
  logic          ow_da_stall;
  logic          ow_mem_req, ow_mem_we;
  logic [AW-1:0] ow_mem_addr;
  logic [DW-1:0] ow_mem_wdata;
  logic          iw_mem_rvalid;
  logic [DW-1:0] iw_mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst),
    .iw_if_req(iw_if_req), .iw_if_addr(iw_if_addr),
    .ow_if_ack(ow_if_ack), .ow_if_rdata(ow_if_rdata), .ow_if_stall(ow_if_stall),
    .iw_da_req(iw_da_req), .iw_da_we(iw_da_we), .iw_da_addr(iw_da_addr),
    .iw_da_wdata(iw_da_wdata),
    .ow_da_ack(ow_da_ack), .ow_da_rdata(ow_da_rdata), .ow_da_stall(ow_da_stall),
    .ow_mem_req(ow_mem_req), .ow_mem_we(ow_mem_we), .ow_mem_addr(ow_mem_addr),
    .ow_mem_wdata(ow_mem_wdata),
    .iw_mem_rvalid(iw_mem_rvalid), .iw_mem_rdata(iw_mem_rdata)
  );

  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;

  typedef struct {int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} cmd_t;
  typedef struct {int cyc; logic [DW-1:0] val;} ack_t;

  cmd_t cmd_q[$];
  ack_t if_q[$];
  ack_t da_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: who owns the port, pending acks, starvation count, returned data
  int            m_owner = 0;
  logic          m_if_ack = 1'b0, m_da_ack = 1'b0, m_store = 1'b0;
  int            m_starve = 0;
  logic [DW-1:0] m_if_rdata = '0, m_da_rdata = '0;

  // stimulus knobs
  int            if_rate = 0, da_rate = 0, st_rate = 0, fixed_lat = 0, tgt = -1;
  logic          spur_en = 1'b0, force_en = 1'b0;
  logic [DW-1:0] force_data = '0;

  // monitor bookkeeping
  int            last_if_ack_cyc = -1, last_mem_cyc = -1, ack_cnt = 0, if_ack_cnt = 0;
  logic [AW-1:0] last_mem_addr = '0;
  logic [DW-1:0] last_mem_wdata = '0;
  logic          last_mem_we = 1'b0;
  cmd_t          mon_c;
  ack_t          mon_a;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_if_ack = 1'b0; m_da_ack = 1'b0; m_store = 1'b0; m_starve = 0;
    m_if_rdata = '0; m_da_rdata = '0;
    cmd_q.delete(); if_q.delete(); da_q.delete();
  endtask

  task automatic model_step();
    logic nif, nda, gif, gda, if_el, da_el;
    nif = 1'b0; nda = 1'b0; gif = 1'b0; gda = 1'b0;
    if (m_owner == 1) begin
      if (iw_mem_rvalid) begin
        nif = 1'b1; m_if_rdata = iw_mem_rdata; m_owner = 0;
        if_q.push_back('{cyc, m_if_rdata});
      end
    end else if (m_owner == 2) begin
      if (iw_mem_rvalid) begin
        nda = 1'b1; m_owner = 0;
        if (!m_store) m_da_rdata = iw_mem_rdata;
        da_q.push_back('{cyc, m_da_rdata});
      end
    end else begin
      if_el = iw_if_req && !m_if_ack;
      da_el = iw_da_req && !m_da_ack;
      // data wins unless fetch is pending and has already lost SM times in a row
      if (da_el && !(if_el && m_starve == SM)) gda = 1'b1;
      else if (if_el)                          gif = 1'b1;
      if (gda) begin
        m_owner = 2; m_store = iw_da_we;
        cmd_q.push_back('{cyc, iw_da_we, iw_da_addr, iw_da_wdata});
      end
      if (gif) begin
        m_owner = 1; m_store = 1'b0;
        cmd_q.push_back('{cyc, 1'b0, iw_if_addr, '0});
      end
    end
    if (!iw_if_req || gif)          m_starve = 0;
    else if (gda && m_starve < SM)  m_starve = m_starve + 1;
    m_if_ack = nif;
    m_da_ack = nda;
  endtask

  initial forever begin
    @(posedge iw_clk);
    cyc++;
    if (iw_rst) model_reset();
    else        model_step();
  end

  initial forever begin
    @(posedge iw_rst);
    model_reset();
  end

  // monitor
  initial forever begin
    @(negedge iw_clk);
    if (iw_rst) begin
      chk("reset_outputs", 128'({ow_if_ack, ow_if_rdata, ow_if_stall, ow_da_ack, ow_da_rdata,
                                 ow_da_stall, ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata}),
          128'(0));
    end else begin
      chk("if_stall", 128'(ow_if_stall), 128'(iw_if_req & ~m_if_ack));
      chk("da_stall", 128'(ow_da_stall), 128'(iw_da_req & ~m_da_ack));
      chk("if_rdata_hold", 128'(ow_if_rdata), 128'(m_if_rdata));
      chk("da_rdata_hold", 128'(ow_da_rdata), 128'(m_da_rdata));
      if (ow_mem_req) begin
        last_mem_cyc = cyc; last_mem_addr = ow_mem_addr;
        last_mem_we = ow_mem_we; last_mem_wdata = ow_mem_wdata;
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_req: actual strobe expected none (cycle %0d)", cyc);
        end else begin
          mon_c = cmd_q.pop_front();
          chk("mem_req_cycle", 128'(cyc), 128'(mon_c.cyc));
          chk("mem_cmd", 128'({ow_mem_we, ow_mem_addr, ow_mem_wdata}),
              128'({mon_c.we, mon_c.addr, mon_c.wdata}));
        end
      end
      if (ow_if_ack) begin
        ack_cnt++; if_ack_cnt++; last_if_ack_cyc = cyc;
        if (if_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_ack: actual pulse expected none (cycle %0d)", cyc);
        end else begin
          mon_a = if_q.pop_front();
          chk("if_ack_cycle", 128'(cyc), 128'(mon_a.cyc));
          chk("if_ack_rdata", 128'(ow_if_rdata), 128'(mon_a.val));
        end
      end
      if (ow_da_ack) begin
        ack_cnt++;
        if (da_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL da_ack: actual pulse expected none (cycle %0d)", cyc);
        end else begin
          mon_a = da_q.pop_front();
          chk("da_ack_cycle", 128'(cyc), 128'(mon_a.cyc));
          chk("da_ack_rdata", 128'(ow_da_rdata), 128'(mon_a.val));
        end
      end
      while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL mem_req_missing: actual none expected strobe at cycle %0d", cmd_q[0].cyc);
        void'(cmd_q.pop_front());
      end
      while (if_q.size() > 0 && if_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL if_ack_missing: actual none expected pulse at cycle %0d", if_q[0].cyc);
        void'(if_q.pop_front());
      end
      while (da_q.size() > 0 && da_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL da_ack_missing: actual none expected pulse at cycle %0d", da_q[0].cyc);
        void'(da_q.pop_front());
      end
    end
  end

  // requesters: hold each request until its ack, then optionally raise a new one
  initial begin
    logic ifa, daa;
    forever begin
      @(negedge iw_clk);
      ifa = ow_if_ack; daa = ow_da_ack;
      @(posedge iw_clk); #1;
      if (!iw_if_req || ifa) begin
        iw_if_req  = (int'($urandom_range(0, 99)) < if_rate);
        iw_if_addr = AW'($urandom);
      end
      if (!iw_da_req || daa) begin
        iw_da_req   = (int'($urandom_range(0, 99)) < da_rate);
        iw_da_we    = (int'($urandom_range(0, 99)) < st_rate);
        iw_da_addr  = AW'($urandom);
        iw_da_wdata = DW'($urandom);
      end
    end
  end

  // memory: completes each command after a latency of 1..4 cycles
  initial begin
    logic rv;
    forever begin
      @(posedge iw_clk); #2;
      rv = (cyc == tgt);
      if (!rv && spur_en && m_owner == 0 && $urandom_range(0, 5) == 0) rv = 1'b1;
      iw_mem_rvalid = rv;
      iw_mem_rdata  = (rv && force_en) ? force_data : DW'($urandom);
      if (ow_mem_req) tgt = cyc + ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4)));
    end
  end

  task automatic wait_quiet(input int maxc, input string name);
    int n = 0;
    while (!(!iw_if_req && !iw_da_req && m_owner == 0 && cmd_q.size() == 0 &&
             if_q.size() == 0 && da_q.size() == 0) && n < maxc) begin
      @(negedge iw_clk); n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s_timeout: actual still busy expected idle within %0d cycles", name, maxc);
    end
  endtask

  task automatic wait_mem(input int maxc, input string name);
    int n = 0;
    do begin @(negedge iw_clk); n++; end while (!ow_mem_req && n < maxc);
    checks++;
    if (!ow_mem_req) begin
      errors++;
      $display("FAIL %s_timeout: actual no mem_req expected one within %0d cycles", name, maxc);
    end
  endtask

  initial begin
    int start, base;
    logic [DW-1:0] prev;
    iw_rst = 1'b1; iw_if_req = 1'b0; iw_if_addr = '0; iw_da_req = 1'b0; iw_da_we = 1'b0;
    iw_da_addr = '0; iw_da_wdata = '0; iw_mem_rvalid = 1'b0; iw_mem_rdata = '0;

    // reset held during traffic, then data wins the first grant
    repeat (2) @(posedge iw_clk); #3;
    iw_if_req = 1'b1; iw_if_addr = 24'h000040;
    iw_da_req = 1'b1; iw_da_we = 1'b0; iw_da_addr = 24'h000080; iw_da_wdata = '0;
    repeat (3) @(posedge iw_clk); #3;
    iw_rst = 1'b0;
    wait_mem(20, "t1_grant");
    chk("t1_first_grant", 128'({ow_mem_we, ow_mem_addr}), 128'({1'b0, 24'h000080}));
    wait_quiet(100, "t1");

    // fetch only, L=2
    fixed_lat = 2; force_en = 1'b1; force_data = 24'hABCDEF;
    @(posedge iw_clk); #3;
    iw_if_req = 1'b1; iw_if_addr = 24'h000010; start = cyc;
    wait_quiet(50, "t2");
    chk("t2_mem_req_cycle", 128'(last_mem_cyc - start), 128'(1));
    chk("t2_mem_cmd", 128'({last_mem_we, last_mem_addr}), 128'({1'b0, 24'h000010}));
    chk("t2_ack_cycle", 128'(last_if_ack_cyc - start), 128'(4));
    chk("t2_rdata", 128'(ow_if_rdata), 128'(24'hABCDEF));
    force_en = 1'b0; fixed_lat = 0;

    // simultaneous requests: data first, fetch second
    @(posedge iw_clk); #3;
    iw_if_req = 1'b1; iw_if_addr = 24'h000020;
    iw_da_req = 1'b1; iw_da_we = 1'b0; iw_da_addr = 24'h000200;
    wait_quiet(100, "t3");
    chk("t3_fetch_last", 128'({last_mem_we, last_mem_addr}), 128'({1'b0, 24'h000020}));

    // fetch held while data re-raises after every ack
    base = if_ack_cnt;
    if_rate = 100; da_rate = 100; st_rate = 30;
    repeat (80) @(posedge iw_clk);
    if_rate = 0; da_rate = 0; st_rate = 0;
    wait_quiet(100, "t4");
    chk("t4_fetch_progress", 128'(if_ack_cnt - base > 0), 128'(1));

    // store keeps load data register unchanged
    prev = m_da_rdata;
    @(posedge iw_clk); #3;
    iw_da_req = 1'b1; iw_da_we = 1'b1; iw_da_addr = 24'h000300; iw_da_wdata = 24'h123456;
    wait_quiet(50, "t5");
    chk("t5_cmd", 128'({last_mem_we, last_mem_addr, last_mem_wdata}),
        128'({1'b1, 24'h000300, 24'h123456}));
    chk("t5_rdata_kept", 128'(ow_da_rdata), 128'(prev));

    // spurious completions while idle
    base = ack_cnt; spur_en = 1'b1;
    repeat (30) @(posedge iw_clk);
    spur_en = 1'b0;
    chk("t6_spurious_no_ack", 128'(ack_cnt - base), 128'(0));

    // reset one cycle after the command, completion arrives afterwards
    fixed_lat = 4;
    @(posedge iw_clk); #3;
    iw_if_req = 1'b1; iw_if_addr = 24'h000050;
    wait_mem(20, "t6_grant");
    @(posedge iw_clk); #1;
    iw_rst = 1'b1; iw_if_req = 1'b0;
    @(posedge iw_clk); #1;
    iw_rst = 1'b0;
    base = ack_cnt;
    repeat (8) @(posedge iw_clk);
    chk("t6_late_rvalid_no_ack", 128'(ack_cnt - base), 128'(0));
    fixed_lat = 0;

    // random traffic
    if_rate = 40; da_rate = 50; st_rate = 40; spur_en = 1'b1;
    repeat (3000) @(posedge iw_clk);
    if_rate = 0; da_rate = 0; st_rate = 0; spur_en = 1'b0;
    wait_quiet(200, "final");
    chk("queues_drained", 128'(cmd_q.size() + if_q.size() + da_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
